// File: rtl/rx_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_timer_pkg
// Brief    : Shared constants and helper functions for the RX bit timer.
// Revision : 1.0 - initial release
// ============================================================================
package rx_timer_pkg;

    // Default configuration of the RX bit timer.
    localparam int c_DEF_CLKS_PER_BIT  = 8;
    localparam int c_DEF_SAMPLE_DELAY  = 3;
    localparam int c_DEF_BITS_PER_WORD = 8;
    localparam int c_DEF_EDGE_TOL      = 1;

    // Phase counter type sized for the default bit period.
    typedef logic [$clog2(c_DEF_CLKS_PER_BIT)-1:0] phase_t;

    // Phase value loaded on a resync edge so that the sample strobe lands
    // exactly 'delay' cycles after the edge cycle.
    function automatic int edge_load(input int clks, input int delay);
        return clks - delay;
    endfunction

    // Phase the counter is expected to hold when a well-aligned edge arrives:
    // one step before the reload value, modulo the bit period.
    function automatic int exp_edge_phase(input int clks, input int delay);
        return (clks - delay - 1 + clks) % clks;
    endfunction

endpackage : rx_timer_pkg
`default_nettype wire

// File: rtl/rx_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : rx_phase_gen
// Brief    : Bit-phase counter with edge resync, sample strobe generation and
//            phase-error detection on resync edges.
// Revision : 1.0 - initial release
// ============================================================================
module rx_phase_gen
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_DELAY = 3,
    parameter int EDGE_TOL     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic rcving,
    input  logic d_edge,
    input  logic resync_en,
    output logic shift_enable,
    output logic edge_err
);

    localparam int c_PH_W = $clog2(CLKS_PER_BIT);
    localparam int c_D_W  = c_PH_W + 1;

    localparam logic [c_PH_W-1:0] c_LOAD = c_PH_W'(edge_load(CLKS_PER_BIT, SAMPLE_DELAY));
    localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(CLKS_PER_BIT - 1);
    localparam logic [c_D_W-1:0]  c_EXP  = c_D_W'(exp_edge_phase(CLKS_PER_BIT, SAMPLE_DELAY));
    localparam logic [c_D_W-1:0]  c_N    = c_D_W'(CLKS_PER_BIT);
    localparam logic [c_D_W-1:0]  c_TOL  = c_D_W'(EDGE_TOL);

    logic [c_PH_W-1:0] r_ph;
    logic              r_first_edge_seen;
    logic              r_shift_enable;
    logic              r_edge_err;

    logic              w_resync;
    logic [c_PH_W-1:0] w_ph_inc;
    logic [c_PH_W-1:0] w_ph_next;
    logic [c_D_W-1:0]  w_ph_ext;
    logic [c_D_W-1:0]  w_diff;
    logic [c_D_W-1:0]  w_dist;
    logic              w_out_of_tol;

    // Next phase and circular phase error of the current edge.
    always_comb begin
        w_resync     = d_edge && resync_en;
        w_ph_inc     = (r_ph == c_LAST) ? '0 : r_ph + 1'b1;
        w_ph_next    = w_resync ? c_LOAD : w_ph_inc;
        w_ph_ext     = {1'b0, r_ph};
        w_diff       = (w_ph_ext >= c_EXP) ? (w_ph_ext - c_EXP) : (c_EXP - w_ph_ext);
        w_dist       = (w_diff > (c_N - w_diff)) ? (c_N - w_diff) : w_diff;
        w_out_of_tol = (w_dist > c_TOL);
    end

    // Phase register, first-edge flag and registered strobes; idle forces reload state.
    always_ff @(posedge clk) begin
        if (reset || !rcving) begin
            r_ph              <= c_LOAD;
            r_first_edge_seen <= 1'b0;
            r_shift_enable    <= 1'b0;
            r_edge_err        <= 1'b0;
        end else begin
            r_ph           <= w_ph_next;
            r_shift_enable <= (w_ph_next == c_LAST);
            // The first edge of a packet only establishes the phase reference.
            r_edge_err     <= w_resync && r_first_edge_seen && w_out_of_tol;
            if (w_resync) begin
                r_first_edge_seen <= 1'b1;
            end
        end
    end

    assign shift_enable = r_shift_enable;
    assign edge_err     = r_edge_err;

endmodule : rx_phase_gen
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : rx_bit_timer
// Brief    : Receive bit timer: per-bit sample strobe, stuffed-bit skipping,
//            word-complete pulse and resync phase-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = c_DEF_CLKS_PER_BIT,
    parameter int SAMPLE_DELAY  = c_DEF_SAMPLE_DELAY,
    parameter int BITS_PER_WORD = c_DEF_BITS_PER_WORD,
    parameter int EDGE_TOL      = c_DEF_EDGE_TOL
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             d_edge,
    input  logic                             rcving,
    input  logic                             stuff_bit,
    input  logic                             resync_en,
    output logic                             shift_enable,
    output logic                             word_received,
    output logic [$clog2(BITS_PER_WORD)-1:0] bit_index,
    output logic                             edge_err
);

    localparam int                 c_IDX_W    = $clog2(BITS_PER_WORD);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(BITS_PER_WORD - 1);

    logic               w_shift_enable;
    logic               w_count;
    logic               w_last_bit;
    logic [c_IDX_W-1:0] r_bit_index;
    logic               r_word_received;

    rx_phase_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_DELAY (SAMPLE_DELAY),
        .EDGE_TOL     (EDGE_TOL)
    ) u_phase_gen (
        .clk          (clk),
        .reset        (reset),
        .rcving       (rcving),
        .d_edge       (d_edge),
        .resync_en    (resync_en),
        .shift_enable (w_shift_enable),
        .edge_err     (edge_err)
    );

    // A strobe counts as a data bit only when the decoder has not marked it stuffed.
    always_comb begin
        w_count    = w_shift_enable && !stuff_bit;
        w_last_bit = (r_bit_index == c_IDX_LAST);
    end

    // Bit counter and one-cycle word-complete pulse; idle clears mid-word.
    always_ff @(posedge clk) begin
        if (reset || !rcving) begin
            r_bit_index     <= '0;
            r_word_received <= 1'b0;
        end else begin
            r_word_received <= w_count && w_last_bit;
            if (w_count) begin
                r_bit_index <= w_last_bit ? '0 : r_bit_index + 1'b1;
            end
        end
    end

    assign shift_enable  = w_shift_enable;
    assign word_received = r_word_received;
    assign bit_index     = r_bit_index;

endmodule : rx_bit_timer
`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_bit_timer
// Brief    : Self-checking bench for rx_bit_timer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_bit_timer;

    localparam int c_N    = 8;
    localparam int c_SD   = 3;
    localparam int c_BPW  = 8;
    localparam int c_TOL  = 1;
    localparam int c_LOAD = c_N - c_SD;
    localparam int c_E    = (c_LOAD - 1 + c_N) % c_N;

    logic       clk;
    logic       reset;
    logic       d_edge;
    logic       rcving;
    logic       stuff_bit;
    logic       resync_en;
    logic       shift_enable;
    logic       word_received;
    logic [2:0] bit_index;
    logic       edge_err;

    int total = 0;
    int bad   = 0;

    // Model state: cycle number, cycle the phase was last loaded, expected outputs.
    int cyc    = 0;
    int c_load = 0;
    int m_se   = 0;
    int m_wr   = 0;
    int m_idx  = 0;
    int m_err  = 0;
    int m_seen = 0;
    int m_ph, m_d, m_dist;

    rx_bit_timer dut (
        .clk           (clk),
        .reset         (reset),
        .d_edge        (d_edge),
        .rcving        (rcving),
        .stuff_bit     (stuff_bit),
        .resync_en     (resync_en),
        .shift_enable  (shift_enable),
        .word_received (word_received),
        .bit_index     (bit_index),
        .edge_err      (edge_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: the phase is the reload value plus elapsed cycles since the
    // last load, and a strobe falls SAMPLE_DELAY-1 cycles into every bit period after it.
    initial begin
        forever begin
            @(posedge clk);
            m_ph = (c_LOAD + (cyc - c_load)) % c_N;
            if (reset || !rcving) begin
                c_load = cyc + 1;
                m_se = 0; m_wr = 0; m_idx = 0; m_err = 0; m_seen = 0;
            end else begin
                m_wr  = 0;
                m_err = 0;
                if (m_se != 0 && !stuff_bit) begin
                    if (m_idx == c_BPW - 1) begin
                        m_idx = 0;
                        m_wr  = 1;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
                if (d_edge && resync_en) begin
                    if (m_seen != 0) begin
                        m_d    = (m_ph > c_E) ? (m_ph - c_E) : (c_E - m_ph);
                        m_dist = (m_d < c_N - m_d) ? m_d : (c_N - m_d);
                        m_err  = (m_dist > c_TOL) ? 1 : 0;
                    end
                    m_seen = 1;
                    c_load = cyc + 1;
                end
                m_se = (((cyc + 1 - c_load) % c_N) == c_SD - 1) ? 1 : 0;
            end
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                check("model_shift_enable",  32'(shift_enable),  32'(m_se));
                check("model_word_received", 32'(word_received), 32'(m_wr));
                check("model_bit_index",     32'(bit_index),     32'(m_idx));
                check("model_edge_err",      32'(edge_err),      32'(m_err));
            end
        end
    end

    task automatic do_reset(input logic rc);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1; rcving = rc; d_edge = 1'b0; stuff_bit = 1'b0; resync_en = 1'b1;
            if (i == 1) begin
                check("rst_shift_enable", 32'(shift_enable), 0);
                check("rst_word_received", 32'(word_received), 0);
                check("rst_bit_index", 32'(bit_index), 0);
                check("rst_edge_err", 32'(edge_err), 0);
            end
        end
    endtask

    // Hand-computed expectations at specific cycles of each scenario.
    task automatic literal_checks(input int id, input int loc);
        case (id)
            1: begin
                if (loc == 0 || loc == 1) begin
                    check("s1_post_rst_se", 32'(shift_enable), 0);
                    check("s1_post_rst_idx", 32'(bit_index), 0);
                end
                if (loc == 2) check("s1_freerun_se", 32'(shift_enable), 1);
            end
            2: begin
                if (loc == 12) check("s2_se12", 32'(shift_enable), 0);
                if (loc == 13 || loc == 21 || loc == 69) check("s2_strobe", 32'(shift_enable), 1);
                if (loc == 69) check("s2_idx69", 32'(bit_index), 7);
                if (loc == 69 || loc == 71) check("s2_wr_off", 32'(word_received), 0);
                if (loc == 70) begin
                    check("s2_wr70", 32'(word_received), 1);
                    check("s2_idx70", 32'(bit_index), 0);
                end
            end
            3: begin
                if (loc == 29 || loc == 30 || loc == 31) check("s3_idx_hold", 32'(bit_index), 2);
                if (loc == 38) check("s3_idx38", 32'(bit_index), 3);
                if (loc == 70) check("s3_wr70", 32'(word_received), 0);
                if (loc == 77) check("s3_se77", 32'(shift_enable), 1);
                if (loc == 78) check("s3_wr78", 32'(word_received), 1);
            end
            4: begin
                if (loc == 19 || loc == 28 || loc == 39) check("s4_err_off", 32'(edge_err), 0);
                if (loc == 38) check("s4_err38", 32'(edge_err), 1);
                if (loc == 30 || loc == 40) check("s4_resync_se", 32'(shift_enable), 1);
                if (loc == 29 || loc == 38) check("s4_old_grid_se", 32'(shift_enable), 0);
            end
            5: begin
                if (loc == 42) check("s5_idx42", 32'(bit_index), 4);
                if (loc == 43) begin
                    check("s5_idle_se", 32'(shift_enable), 0);
                    check("s5_idle_idx", 32'(bit_index), 0);
                    check("s5_idle_wr", 32'(word_received), 0);
                    check("s5_idle_err", 32'(edge_err), 0);
                end
                if (loc == 45) check("s5_se45", 32'(shift_enable), 0);
                if (loc == 63) begin
                    check("s5_se63", 32'(shift_enable), 1);
                    check("s5_idx63", 32'(bit_index), 0);
                end
                if (loc == 64) check("s5_idx64", 32'(bit_index), 1);
            end
            6: begin
                if (loc == 18 || loc == 35) check("s6_no_resync_se", 32'(shift_enable), 0);
                if (loc == 21 || loc == 29 || loc == 37) check("s6_grid_se", 32'(shift_enable), 1);
                if (loc == 16 || loc == 26) check("s6_err", 32'(edge_err), 0);
            end
            7: begin
                if (loc == 21 || loc == 24) check("s7_se", 32'(shift_enable), 1);
                if (loc == 29) check("s7_se29", 32'(shift_enable), 0);
                if (loc == 22) begin
                    check("s7_err22", 32'(edge_err), 1);
                    check("s7_idx22", 32'(bit_index), 2);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_case(input int id, input int len);
        for (int loc = 0; loc < len; loc++) begin
            @(posedge clk);
            #1;
            reset     = 1'b0;
            rcving    = (id == 1) ? 1'b1 : (loc >= 10);
            d_edge    = (id != 1) && (loc == 10);
            resync_en = 1'b1;
            stuff_bit = 1'b0;
            case (id)
                3: stuff_bit = (loc == 29);
                4: d_edge = (loc == 10 || loc == 18 || loc == 27 || loc == 37);
                5: begin
                    rcving = (loc >= 10 && loc < 42) || (loc >= 60);
                    d_edge = (loc == 10 || loc == 60);
                end
                6: begin
                    resync_en = (loc == 10);
                    d_edge    = (loc == 10) || (loc > 10 && (loc % 5) == 0);
                end
                7: d_edge = (loc == 10 || loc == 21);
                default: ;
            endcase
            literal_checks(id, loc);
        end
    endtask

    initial begin
        reset = 1'b1; rcving = 1'b1; d_edge = 1'b0; stuff_bit = 1'b0; resync_en = 1'b1;
        for (int id = 1; id <= 7; id++) begin
            do_reset(1'b1);
            run_case(id, 90);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rx_bit_timer
`default_nettype wire
